// File: rtl/ervp_cache_uca_bridge.sv
// Request/reply bridge between a cache and a UCA-style port: tracks in-flight request types
// and turns read replies into registered upstream replies. Optional check macro: ERVP_CACHE_UCA_BRIDGE_RESP_CHECK_EN.
module ervp_cache_uca_bridge #(
    parameter int BW_ADDR         = 32,
    parameter int BW_ACCESS       = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   rstnn,
    input  logic                   clear,
    input  logic                   enable,
    output logic                   busy,
    output logic                   rcqready,
    input  logic                   rcqvalid,
    input  logic [BW_ADDR-1:0]     rcqaddr,
    input  logic                   rcqwrite,
    input  logic [BW_ACCESS/8-1:0] rcqwstrb,
    input  logic [BW_ACCESS-1:0]   rcqwdata,
    output logic                   rcyvalid,
    output logic [BW_ACCESS-1:0]   rcyrdata,
    input  logic                   sxqready,
    output logic                   sxqvalid,
    output logic [BW_ADDR-1:0]     sxqaddr,
    output logic                   sxqwrite,
    output logic [BW_ACCESS/8-1:0] sxqwstrb,
    output logic [BW_ACCESS-1:0]   sxqwdata,
    input  logic                   sxyvalid,
    input  logic                   sxywreply,
    input  logic [1:0]             sxyresp,
    input  logic [BW_ACCESS-1:0]   sxyrdata,
    output logic                   error
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

    logic [CW-1:0]              count_q, count_d;
    logic [PW-1:0]              wptr_q, wptr_d;
    logic [PW-1:0]              rptr_q, rptr_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic                       rcyvalid_q, rcyvalid_d;
    logic [BW_ACCESS-1:0]       rcyrdata_q, rcyrdata_d;

    logic full;
    logic accept;
    logic push;
    logic pop;
    logic head;

    assign full   = (count_q == MAX_CNT);
    assign accept = enable & ~full & ~clear;

    assign sxqvalid = rcqvalid & accept;
    assign rcqready = sxqready & accept;
    assign sxqaddr  = rcqaddr;
    assign sxqwrite = rcqwrite;
    assign sxqwstrb = rcqwstrb;
    assign sxqwdata = rcqwdata;

    // Replies with nothing outstanding never pop, so the count cannot underflow.
    assign push = sxqvalid & sxqready;
    assign pop  = sxyvalid & (count_q != '0);
    assign head = fifo_q[rptr_q];

    always_comb begin
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        fifo_d     = fifo_q;
        rcyvalid_d = 1'b0;
        rcyrdata_d = rcyrdata_q;

        if (push) begin
            fifo_d[wptr_q] = rcqwrite;
            wptr_d         = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Write replies are absorbed here; only read replies go upstream.
        if (pop && !head) begin
            rcyvalid_d = 1'b1;
            rcyrdata_d = sxyrdata;
        end

        if (clear) begin
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            rcyvalid_d = 1'b0;
            rcyrdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            rcyvalid_q <= 1'b0;
            rcyrdata_q <= '0;
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rcyvalid_q <= rcyvalid_d;
            rcyrdata_q <= rcyrdata_d;
        end
    end

    // Type storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign rcyvalid = rcyvalid_q;
    assign rcyrdata = rcyrdata_q;
    assign busy     = (count_q != '0) | rcyvalid_q;

`ifdef ERVP_CACHE_UCA_BRIDGE_RESP_CHECK_EN
    logic error_q, error_d;

    // Sticky: clear flushes the queue but leaves the flag until reset.
    always_comb begin
        error_d = error_q
                | (pop & ((sxyresp != 2'b00) | (sxywreply != head)))
                | (sxyvalid & (count_q == '0));
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    logic unused_reply_info;
    assign unused_reply_info = ^{sxyresp, sxywreply};
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_ervp_cache_uca_bridge.sv
// Self-checking bench for ervp_cache_uca_bridge: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ervp_cache_uca_bridge;

`ifdef ERVP_CACHE_UCA_BRIDGE_RESP_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk;
    logic        rstnn;
    logic        clear;
    logic        enable;
    logic        busy;
    logic        rcqready;
    logic        rcqvalid;
    logic [31:0] rcqaddr;
    logic        rcqwrite;
    logic [3:0]  rcqwstrb;
    logic [31:0] rcqwdata;
    logic        rcyvalid;
    logic [31:0] rcyrdata;
    logic        sxqready;
    logic        sxqvalid;
    logic [31:0] sxqaddr;
    logic        sxqwrite;
    logic [3:0]  sxqwstrb;
    logic [31:0] sxqwdata;
    logic        sxyvalid;
    logic        sxywreply;
    logic [1:0]  sxyresp;
    logic [31:0] sxyrdata;
    logic        error;

    int errors = 0;
    int checks = 0;
    int pulseCount = 0;

    bit          modelQ[$];
    bit          modelValid = 1'b0;
    bit          expRcyValid = 1'b0;
    logic [31:0] expRcyData = '0;
    bit          expError = 1'b0;

    ervp_cache_uca_bridge #(
        .BW_ADDR(32),
        .BW_ACCESS(32),
        .MAX_OUTSTANDING(DEPTH)
    ) dut (
        .clk(clk),
        .rstnn(rstnn),
        .clear(clear),
        .enable(enable),
        .busy(busy),
        .rcqready(rcqready),
        .rcqvalid(rcqvalid),
        .rcqaddr(rcqaddr),
        .rcqwrite(rcqwrite),
        .rcqwstrb(rcqwstrb),
        .rcqwdata(rcqwdata),
        .rcyvalid(rcyvalid),
        .rcyrdata(rcyrdata),
        .sxqready(sxqready),
        .sxqvalid(sxqvalid),
        .sxqaddr(sxqaddr),
        .sxqwrite(sxqwrite),
        .sxqwstrb(sxqwstrb),
        .sxqwdata(sxqwdata),
        .sxyvalid(sxyvalid),
        .sxywreply(sxywreply),
        .sxyresp(sxyresp),
        .sxyrdata(sxyrdata),
        .error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Reference model: a queue of outstanding request types, advanced on every rising edge.
    always @(posedge clk) begin
        bit doPush;
        bit doPop;
        bit headType;
        if (!rstnn) begin
            modelQ.delete();
            expRcyValid = 1'b0;
            expRcyData  = '0;
            expError    = 1'b0;
            modelValid  = 1'b1;
        end else begin
            doPush   = rcqvalid && enable && (modelQ.size() < DEPTH) && !clear && sxqready;
            doPop    = sxyvalid && (modelQ.size() > 0);
            headType = doPop ? modelQ[0] : 1'b0;
            if (CHECK_EN) begin
                if (doPop && ((sxyresp != 2'b00) || (sxywreply != headType))) expError = 1'b1;
                if (sxyvalid && modelQ.size() == 0) expError = 1'b1;
            end
            if (clear) begin
                modelQ.delete();
                expRcyValid = 1'b0;
                expRcyData  = '0;
            end else begin
                if (doPop) void'(modelQ.pop_front());
                expRcyValid = doPop && !headType;
                if (expRcyValid) expRcyData = sxyrdata;
                if (doPush) modelQ.push_back(rcqwrite);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit accExp;
        if (modelValid) begin
            accExp = enable && (modelQ.size() < DEPTH) && !clear;
            checkOutput("sxqvalid", {31'b0, sxqvalid}, {31'b0, rcqvalid && accExp});
            checkOutput("rcqready", {31'b0, rcqready}, {31'b0, sxqready && accExp});
            checkOutput("sxqaddr", sxqaddr, rcqaddr);
            checkOutput("sxqwrite", {31'b0, sxqwrite}, {31'b0, rcqwrite});
            checkOutput("sxqwstrb", {28'b0, sxqwstrb}, {28'b0, rcqwstrb});
            checkOutput("sxqwdata", sxqwdata, rcqwdata);
            checkOutput("rcyvalid", {31'b0, rcyvalid}, {31'b0, expRcyValid});
            checkOutput("rcyrdata", rcyrdata, expRcyData);
            checkOutput("busy", {31'b0, busy}, {31'b0, (modelQ.size() != 0) || expRcyValid});
            checkOutput("error", {31'b0, error}, {31'b0, expError});
            if (rcyvalid === 1'b1) pulseCount++;
        end
    end

    task automatic applyStimulus(input bit vld, input bit wr, input logic [31:0] addr, input logic [31:0] wdat,
                                 input bit rv, input bit rw, input logic [31:0] rdat);
        rcqvalid  = vld;
        rcqwrite  = wr;
        rcqaddr   = addr;
        rcqwdata  = wdat;
        rcqwstrb  = wr ? 4'hF : 4'h0;
        sxyvalid  = rv;
        sxywreply = rw;
        sxyrdata  = rdat;
        #2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic doReset();
        rstnn = 1'b0;
        idle();
        nextCycle();
        rstnn = 1'b1;
    endtask

    initial begin
        int base;
        rstnn    = 1'b0;
        clear    = 1'b0;
        enable   = 1'b1;
        sxqready = 1'b1;
        sxyresp  = 2'b00;
        rcqvalid = 1'b0; rcqwrite = 1'b0; rcqaddr = '0; rcqwdata = '0; rcqwstrb = '0;
        sxyvalid = 1'b0; sxywreply = 1'b0; sxyrdata = '0;
        @(posedge clk);
        nextCycle();
        rstnn = 1'b1;
        idle();
        checkOutput("reset_rcyvalid", {31'b0, rcyvalid}, 32'd0);
        checkOutput("reset_rcyrdata", rcyrdata, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_error", {31'b0, error}, 32'd0);
        checkOutput("reset_rcqready", {31'b0, rcqready}, 32'd1);

        // Single read
        applyStimulus(1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("rd_sxqvalid", {31'b0, sxqvalid}, 32'd1);
        checkOutput("rd_sxqaddr", sxqaddr, 32'h1000);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        checkOutput("rd_busy_outstanding", {31'b0, busy}, 32'd1);
        nextCycle();
        idle();
        checkOutput("rd_rcyvalid", {31'b0, rcyvalid}, 32'd1);
        checkOutput("rd_rcyrdata", rcyrdata, 32'hDEADBEEF);
        nextCycle();
        checkOutput("rd_rcyvalid_drop", {31'b0, rcyvalid}, 32'd0);
        checkOutput("rd_busy_drop", {31'b0, busy}, 32'd0);
        checkOutput("rd_rcyrdata_hold", rcyrdata, 32'hDEADBEEF);

        // Fill with writes, then free one slot
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h2000 + 32'(i * 4), 32'(i), 1'b0, 1'b0, 32'h0);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b1, 32'h2010, 32'h4, 1'b0, 1'b0, 32'h0);
        checkOutput("fill_rcqready_full", {31'b0, rcqready}, 32'd0);
        checkOutput("fill_sxqvalid_full", {31'b0, sxqvalid}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        checkOutput("fill_rcqready_still_full", {31'b0, rcqready}, 32'd0);
        nextCycle();
        idle();
        checkOutput("fill_rcqready_freed", {31'b0, rcqready}, 32'd1);
        checkOutput("fill_rcyvalid", {31'b0, rcyvalid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
            nextCycle();
        end
        idle();
        nextCycle();
        checkOutput("fill_busy_drained", {31'b0, busy}, 32'd0);

        // Mixed W,R,W,R with in-order replies
        base = pulseCount;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i % 2) == 0, 32'h4000 + 32'(i), 32'h0, 1'b0, 1'b0, 32'h0);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h11);
        nextCycle();
        checkOutput("mix_first_valid", {31'b0, rcyvalid}, 32'd1);
        checkOutput("mix_first_data", rcyrdata, 32'h11);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        nextCycle();
        checkOutput("mix_write_novalid", {31'b0, rcyvalid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h22);
        nextCycle();
        checkOutput("mix_second_data", rcyrdata, 32'h22);
        idle();
        nextCycle();
        checkOutput("mix_pulses", 32'(pulseCount - base), 32'd2);

        // Simultaneous push/pop at count 2, across pointer wrap
        applyStimulus(1'b1, 1'b0, 32'h3100, 32'h0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h3104, 32'h0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, (i % 2) == 1, 32'h3000 + 32'(i), 32'h0, 1'b1, (i % 2) == 1, 32'h100 + 32'(i));
            nextCycle();
            checkOutput("wrap_valid", {31'b0, rcyvalid}, {31'b0, (i % 2) == 0});
            if ((i % 2) == 0) checkOutput("wrap_data", rcyrdata, 32'h100 + 32'(i));
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h200);
        nextCycle();
        checkOutput("wrap_drain_data", rcyrdata, 32'h200);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        nextCycle();
        idle();
        checkOutput("wrap_busy_empty", {31'b0, busy}, 32'd0);

        // Clear with three outstanding
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h5000 + 32'(i), 32'h0, 1'b0, 1'b0, 32'h0);
            nextCycle();
        end
        clear = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h5010, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("clr_sxqvalid", {31'b0, sxqvalid}, 32'd0);
        checkOutput("clr_rcqready", {31'b0, rcqready}, 32'd0);
        nextCycle();
        clear = 1'b0;
        idle();
        checkOutput("clr_busy", {31'b0, busy}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hBAD);
        nextCycle();
        idle();
        checkOutput("clr_late_reply_ignored", {31'b0, rcyvalid}, 32'd0);
        checkOutput("clr_late_reply_error", {31'b0, error}, {31'b0, CHECK_EN});

        // Response checks
        doReset();
        idle();
        checkOutput("chk_reset_error", {31'b0, error}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h6000, 32'h0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        sxyresp = 2'b10;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h55);
        nextCycle();
        sxyresp = 2'b00;
        idle();
        checkOutput("chk_resp_error", {31'b0, error}, {31'b0, CHECK_EN});
        checkOutput("chk_resp_rcyvalid", {31'b0, rcyvalid}, 32'd1);
        clear = 1'b1;
        nextCycle();
        clear = 1'b0;
        nextCycle();
        checkOutput("chk_error_through_clear", {31'b0, error}, {31'b0, CHECK_EN});
        doReset();
        idle();
        checkOutput("chk_error_reset", {31'b0, error}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h7000, 32'h0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h66);
        nextCycle();
        idle();
        checkOutput("chk_type_error", {31'b0, error}, {31'b0, CHECK_EN});
        nextCycle();
        doReset();
        idle();
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ervp_cache_uca_bridge.md
ERVP_CACHE_UCA_BRIDGE -- requirements
Module: ERVP_CACHE_UCA_BRIDGE

Interface
REQ-001 Parameters SHALL be:
- BW_ADDR, 32, address width.
- BW_ACCESS, 32, data width.
- MAX_OUTSTANDING, 4, maximum number of in-flight transactions (power of two, 1..16).

REQ-002 Ports SHALL be as follows. Clock and reset are one clock, with synchronous active-low reset.
- clk  in  1  single clock.
- rstnn  in  1  synchronous active-low reset.
- clear  in  1  synchronous flush.
- enable  in  1  accept gate.
- busy  out  1  work in flight.
- rcqready  out  1  upstream request ready.
- rcqvalid  in  1  upstream request valid.
- rcqaddr  in  BW_ADDR  request address.
- rcqwrite  in  1  1=write.
- rcqwstrb  in  BW_ACCESS/8  write strobe.
- rcqwdata  in  BW_ACCESS  write data.
- rcyvalid  out  1  read reply valid.
- rcyrdata  out  BW_ACCESS  read reply data.
- sxqready  in  1  downstream request ready.
- sxqvalid  out  1  downstream request valid.
- sxqaddr  out  BW_ADDR  address, passed through.
- sxqwrite  out  1  write flag, passed through.
- sxqwstrb  out  BW_ACCESS/8  strobe, passed through.
- sxqwdata  out  BW_ACCESS  data, passed through.
- sxyvalid  in  1  downstream reply valid.
- sxywreply  in  1  1=write reply.
- sxyresp  in  2  AXI response code.
- sxyrdata  in  BW_ACCESS  read data.
- error  out  1  sticky error flag.

Function
REQ-003 The request path SHALL be combinational: sxqvalid = rcqvalid & enable & ~full & ~clear, and the address/write/strobe/data outputs SHALL equal their rcq* inputs.
REQ-004 rcqready SHALL equal sxqready & enable & ~full & ~clear.
REQ-005 A push SHALL occur when sxqvalid & sxqready; it SHALL write rcqwrite into a MAX_OUTSTANDING-deep type FIFO and increment the count.
REQ-006 A pop SHALL occur when sxyvalid is high and the count is nonzero; it SHALL remove the FIFO head and decrement the count.
REQ-007 On a simultaneous push and pop, the count SHALL stay unchanged, and both FIFO pointers SHALL advance modulo MAX_OUTSTANDING.
REQ-008 full SHALL be (count == MAX_OUTSTANDING). The count SHALL be log2(MAX_OUTSTANDING)+1 bits wide and SHALL never exceed MAX_OUTSTANDING or go below 0.
REQ-009 Read reply (popped head = 0): rcyvalid SHALL be 1 and rcyrdata SHALL be sxyrdata, both registered, one cycle after the sxyvalid cycle. rcyvalid SHALL be 0 in all other cycles.
REQ-010 Write reply (popped head = 1): the reply SHALL be consumed internally and SHALL NOT drive rcyvalid.
REQ-011 rcyrdata SHALL hold its last value when rcyvalid is 0.
REQ-012 busy SHALL equal (count != 0) | rcyvalid.
REQ-013 Each downstream reply SHALL be accepted in one cycle; there is no reply backpressure.

Reset
REQ-014 While rstnn = 0 at a clk edge, the following SHALL all become 0: count, FIFO pointers, rcyvalid, rcyrdata and error.
REQ-015 A reset asserted mid-transaction SHALL discard all outstanding entries, and replies arriving later SHALL be treated as unexpected.
REQ-016 clear = 1 SHALL perform the same flush as reset in the same cycle, except that error SHALL be retained. No push SHALL occur in that cycle.

Configuration
REQ-017 With macro ERVP_CACHE_UCA_BRIDGE_RESP_CHECK_EN defined, error SHALL be set and held until reset by any of:
- a pop whose sxyresp != 0;
- a pop where sxywreply differs from the FIFO head;
- sxyvalid arriving while the count is 0.
REQ-018 With the macro undefined, error SHALL be tied to 0 and no check logic SHALL be built. Reply behaviour SHALL be otherwise identical, and a reply arriving with count 0 SHALL be ignored.

Verification
REQ-019 Single read: push read to 0x1000, then sxyvalid with sxywreply = 0 and sxyrdata = 0xDEADBEEF -> next cycle rcyvalid = 1, rcyrdata = 0xDEADBEEF, busy then drops to 0.
REQ-020 Fill: 4 writes accepted with no replies -> rcqready = 0 on the 5th request. Then one write reply -> rcqready = 1 the next cycle, and rcyvalid stays 0 throughout.
REQ-021 Mixed order: requests W, R, W, R, with replies in the same order carrying rdata 0x11 and 0x22 -> exactly two rcyvalid pulses, with data 0x11 then 0x22.
REQ-022 Simultaneous events: with count = 2, push a request and receive a reply in the same cycle -> count stays 2, and the FIFO wraps correctly over 8 consecutive transactions.
REQ-023 Check enabled: a reply with sxyresp = 2'b10, or with sxywreply = 1 against a read head -> error = 1, held through clear, cleared only by rstnn = 0.
REQ-024 clear mid-flight: with 3 outstanding, assert clear -> count = 0, busy = 0, and sxqvalid = 0 during the clear cycle.
